// File: rtl/multi_int_ctrl.sv
// Prioritised multi-channel interrupt controller: latches request edges, arbitrates,
// injects a push/drain micro-sequence into fetch, then redirects the PC to the vector.
module multi_int_ctrl #(
    parameter int unsigned          N_CH          = 4,
    parameter int unsigned          INSTR_W       = 16,
    parameter int unsigned          PC_W          = 32,
    parameter logic [PC_W-1:0]      VEC_BASE      = '0,
    parameter int unsigned          VEC_STRIDE    = 2,
    parameter logic [INSTR_W-1:0]   PUSH_HI_INSTR = '0,
    parameter logic [INSTR_W-1:0]   PUSH_LO_INSTR = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR     = '0,
    parameter int unsigned          DRAIN_CYCLES  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    int_req,
    input  logic [N_CH-1:0]    int_mask,
    input  logic               hold,
    input  logic               rti_done,
    output logic               pc_stop,
    output logic [INSTR_W-1:0] instruction,
    output logic               pc_change,
    output logic [PC_W-1:0]    pc_value,
    output logic [N_CH-1:0]    ack,
    output logic               in_service,
    output logic [N_CH-1:0]    pending
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [N_CH-1:0] CH0_BIT = N_CH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPushHi,
        StPushLo,
        StDrain,
        StVec,
        StActive
    } state_e;

    state_e             state_q, state_d;
    logic [N_CH-1:0]    req_q, req_d;
    logic [N_CH-1:0]    pending_q, pending_d;
    logic [CH_W-1:0]    sel_ch_q, sel_ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pc_stop_q, pc_stop_d;
    logic [INSTR_W-1:0] instruction_q, instruction_d;
    logic               pc_change_q, pc_change_d;
    logic [PC_W-1:0]    pc_value_q, pc_value_d;
    logic [N_CH-1:0]    ack_q, ack_d;
    logic               in_service_q, in_service_d;

    logic [N_CH-1:0]    req_edge;
    logic [N_CH-1:0]    cand;
    logic [N_CH-1:0]    clr_mask;
    logic [CH_W-1:0]    pick_ch;

    always_comb begin
        req_d    = int_req;
        req_edge = int_req & ~req_q;
        cand     = pending_q & int_mask;

        // Descending scan so the lowest set index wins.
        pick_ch = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_ch = CH_W'(i);
            end
        end

        state_d  = state_q;
        sel_ch_d = sel_ch_q;
        cnt_d    = cnt_q;
        clr_mask = '0;

        unique case (state_q)
            StIdle: begin
                if ((cand != '0) && !hold) begin
                    state_d  = StPushHi;
                    sel_ch_d = pick_ch;
                end
            end
            StPushHi: state_d = StPushLo;
            StPushLo: begin
                state_d = StDrain;
                cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StVec;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StVec: begin
                state_d  = StActive;
                clr_mask = CH0_BIT << sel_ch_q;
            end
            StActive: begin
                if (rti_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh edge in the clearing cycle must survive, so set is applied last.
        pending_d = (pending_q & ~clr_mask) | req_edge;

        // Outputs are registered: decode them from the state being entered.
        pc_stop_d     = (state_d == StPushHi) || (state_d == StPushLo) ||
                        (state_d == StDrain)  || (state_d == StVec);
        pc_change_d   = (state_d == StVec);
        in_service_d  = (state_d == StActive);
        pc_value_d    = '0;
        ack_d         = '0;
        instruction_d = NOP_INSTR;

        unique case (state_d)
            StPushHi: instruction_d = PUSH_HI_INSTR;
            StPushLo: instruction_d = PUSH_LO_INSTR;
            StVec: begin
                pc_value_d = VEC_BASE + (PC_W'(sel_ch_d) * PC_W'(VEC_STRIDE));
                ack_d      = CH0_BIT << sel_ch_d;
            end
            default: instruction_d = NOP_INSTR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            req_q         <= '0;
            pending_q     <= '0;
            sel_ch_q      <= '0;
            cnt_q         <= '0;
            pc_stop_q     <= 1'b0;
            instruction_q <= NOP_INSTR;
            pc_change_q   <= 1'b0;
            pc_value_q    <= '0;
            ack_q         <= '0;
            in_service_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            pending_q     <= pending_d;
            sel_ch_q      <= sel_ch_d;
            cnt_q         <= cnt_d;
            pc_stop_q     <= pc_stop_d;
            instruction_q <= instruction_d;
            pc_change_q   <= pc_change_d;
            pc_value_q    <= pc_value_d;
            ack_q         <= ack_d;
            in_service_q  <= in_service_d;
        end
    end

    assign pc_stop     = pc_stop_q;
    assign instruction = instruction_q;
    assign pc_change   = pc_change_q;
    assign pc_value    = pc_value_q;
    assign ack         = ack_q;
    assign in_service  = in_service_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_multi_int_ctrl.sv
// Bench for multi_int_ctrl: directed scenarios then random traffic, every cycle checked
// against a sequence-slot reference model.
module tb_multi_int_ctrl;

    localparam int unsigned N_CH     = 4;
    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned PC_W     = 32;
    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam int unsigned STRIDE   = 2;
    localparam logic [15:0] HI_I     = 16'hA5A1;
    localparam logic [15:0] LO_I     = 16'hA5A2;
    localparam logic [15:0] NOP_I    = 16'h0F00;
    localparam int unsigned DRAIN    = 3;
    // Slots 0..L-1 are the injected sequence (L-1 is the vector cycle), L is the handler.
    localparam int          L        = 2 + DRAIN + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_CH-1:0]    int_req;
    logic [N_CH-1:0]    int_mask;
    logic               hold;
    logic               rti_done;
    logic               pc_stop;
    logic [INSTR_W-1:0] instruction;
    logic               pc_change;
    logic [PC_W-1:0]    pc_value;
    logic [N_CH-1:0]    ack;
    logic               in_service;
    logic [N_CH-1:0]    pending;

    int n_cmp = 0;
    int n_err = 0;

    logic [N_CH-1:0] m_pend = '0;
    logic [N_CH-1:0] m_prev = '0;
    int              m_pos  = -1;
    int              m_sel  = 0;

    always #5 clk = ~clk;

    multi_int_ctrl #(
        .N_CH          (N_CH),
        .INSTR_W       (INSTR_W),
        .PC_W          (PC_W),
        .VEC_BASE      (BASE),
        .VEC_STRIDE    (STRIDE),
        .PUSH_HI_INSTR (HI_I),
        .PUSH_LO_INSTR (LO_I),
        .NOP_INSTR     (NOP_I),
        .DRAIN_CYCLES  (DRAIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .int_req     (int_req),
        .int_mask    (int_mask),
        .hold        (hold),
        .rti_done    (rti_done),
        .pc_stop     (pc_stop),
        .instruction (instruction),
        .pc_change   (pc_change),
        .pc_value    (pc_value),
        .ack         (ack),
        .in_service  (in_service),
        .pending     (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N_CH-1:0] v);
        for (int i = 0; i < int'(N_CH); i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Applies one clock edge's worth of rules to the model, using the inputs at that edge.
    task automatic model_edge();
        logic [N_CH-1:0] edges;
        logic [N_CH-1:0] cand;
        if (reset) begin
            m_pend = '0;
            m_prev = '0;
            m_pos  = -1;
            m_sel  = 0;
        end else begin
            edges = int_req & ~m_prev;
            cand  = m_pend & int_mask;
            if (m_pos == L - 1) m_pend[m_sel] = 1'b0;
            m_pend = m_pend | edges;
            if (m_pos == -1) begin
                if (cand != '0 && !hold) begin
                    m_sel = lowest(cand);
                    m_pos = 0;
                end
            end else if (m_pos < L) begin
                m_pos++;
            end else if (rti_done) begin
                m_pos = -1;
            end
            m_prev = int_req;
        end
    endtask

    task automatic check_all();
        logic        vec;
        logic [15:0] e_instr;
        vec     = (m_pos == L - 1);
        e_instr = (m_pos == 0) ? HI_I : (m_pos == 1) ? LO_I : NOP_I;
        check("pc_stop", 32'(pc_stop), 32'(m_pos >= 0 && m_pos <= L - 1));
        check("instruction", 32'(instruction), 32'(e_instr));
        check("pc_change", 32'(pc_change), 32'(vec));
        check("pc_value", pc_value, vec ? BASE + 32'(m_sel) * 32'(STRIDE) : 32'h0);
        check("ack", 32'(ack), vec ? (32'h1 << m_sel) : 32'h0);
        check("in_service", 32'(in_service), 32'(m_pos == L));
        check("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Steps n cycles; reports the last vector seen (all-ones if none) and pc_stop cycles.
    task automatic run(input int n, output logic [31:0] vec_seen, output int stops);
        vec_seen = 32'hFFFF_FFFF;
        stops    = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (pc_stop) stops++;
            if (pc_change) vec_seen = pc_value;
        end
    endtask

    task automatic rti_pulse();
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int          s;
        logic        found;

        reset = 1'b1; hold = 1'b0; rti_done = 1'b0; int_req = '0; int_mask = 4'hF;
        step(); step(); step();
        reset = 1'b0;
        step(); step();

        // Single channel 2 request.
        int_req = 4'b0100;
        run(10, v, s);
        check("ch2_stop_cycles", 32'(s), 32'd6);
        check("ch2_vector", v, 32'd4);
        check("ch2_in_service", 32'(in_service), 32'd1);
        rti_pulse();
        int_req = '0;
        step(); step();

        // Simultaneous edges on channels 1 and 3.
        int_req = 4'b1010;
        run(10, v, s);
        check("dual_first_vec", v, 32'd2);
        check("dual_pending", 32'(pending), 32'h8);
        rti_pulse();
        run(10, v, s);
        check("dual_second_vec", v, 32'd6);
        rti_pulse();
        int_req = '0;
        step();

        // Masked channel 0 stays pending until unmasked.
        int_mask = 4'b1110;
        int_req  = 4'b0001;
        run(5, v, s);
        check("masked_no_stop", 32'(s), 32'd0);
        check("masked_pending", 32'(pending), 32'h1);
        int_mask = 4'hF;
        step();
        check("unmask_start", 32'(pc_stop), 32'd1);
        run(8, v, s);
        rti_pulse();
        int_req = '0;
        step();

        // hold blocks only the start of a sequence.
        hold    = 1'b1;
        int_req = 4'b0010;
        run(6, v, s);
        check("hold_no_stop", 32'(s), 32'd0);
        hold = 1'b0;
        step();
        check("hold_release_start", 32'(pc_stop), 32'd1);
        step(); step(); step();
        hold = 1'b1;
        run(6, v, s);
        check("hold_mid_drain_vec", v, 32'd2);
        hold = 1'b0;
        rti_pulse();
        int_req = '0;
        step();

        // Reset in the middle of the drain.
        int_req = 4'b0100;
        step(); step(); step(); step(); step();
        reset = 1'b1;
        step();
        check("reset_stop", 32'(pc_stop), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        reset   = 1'b0;
        int_req = '0;
        step();
        int_req = 4'b0100;
        run(10, v, s);
        check("post_reset_vec", v, 32'd4);
        rti_pulse();
        int_req = '0;
        step();

        // Level-high request does not re-request after rti.
        int_req = 4'b0010;
        run(10, v, s);
        rti_pulse();
        run(10, v, s);
        check("level_no_reservice", 32'(s), 32'd0);
        int_req = '0;
        step();

        // Channel 0 edge landing in its own vector cycle.
        int_req = 4'b0001;
        step();
        int_req = '0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pc_change) begin
                found = 1'b1;
                break;
            end
        end
        check("vec_wait", 32'(found), 32'd1);
        int_req = 4'b0001;
        step();
        check("vec_edge_pending", 32'(pending[0]), 32'd1);
        run(4, v, s);
        rti_pulse();
        run(10, v, s);
        check("vec_edge_reservice", v, 32'd0);
        check("vec_edge_stops", 32'(s), 32'd6);
        rti_pulse();
        int_req = '0;
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if ($urandom_range(7) == 0) int_req[i] = ~int_req[i];
            end
            if ($urandom_range(31) == 0) int_mask = 4'($urandom);
            hold     = ($urandom_range(4) == 0);
            rti_done = ($urandom_range(5) == 0);
            reset    = ($urandom_range(199) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_int_ctrl.md
Name: multi_int_ctrl

Overview:
- Parametrised successor of the single-line interrupt control unit, with N_CH prioritised interrupt channels, per-channel masking, edge-latched pending bits and a vector table.
- On an accepted interrupt it freezes the PC and injects a configurable micro-instruction sequence into the fetch stream, ahead of the FD pipeline register: push PC high, push PC low, then drain NOPs.
- It then redirects the PC to the channel vector and blocks further interrupts until RTI completes.
- Sits beside the call/ret/rti FSMs and drives the fetch instruction mux and the PC mux.

Parameters:
- N_CH, 4, number of interrupt channels (1..16); channel 0 has the highest priority.
- INSTR_W, 16, width of an injected instruction.
- PC_W, 32, PC width.
- VEC_BASE, 32'h0000_0000, vector address of channel 0.
- VEC_STRIDE, 2, address step between consecutive channel vectors.
- PUSH_HI_INSTR, 16'h0000, encoding injected to push PC[31:16].
- PUSH_LO_INSTR, 16'h0000, encoding injected to push PC[15:0].
- NOP_INSTR, 16'h0000, encoding injected during drain.
- DRAIN_CYCLES, 3, number of NOPs injected after the pushes (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- int_req  in  N_CH  raw interrupt request lines; a rising edge is a request.
- int_mask  in  N_CH  1 = channel enabled.
- hold  in  1  another FSM (call/ret/rti) or a load-use stall owns fetch; do not start a sequence.
- rti_done  in  1  one-cycle pulse when RTI leaves the pipeline.
- pc_stop  out  1  freeze the PC incrementer and select the injected instruction.
- instruction  out  INSTR_W  injected instruction.
- pc_change  out  1  select pc_value into the PC.
- pc_value  out  PC_W  vector address.
- ack  out  N_CH  one-hot one-cycle acknowledge of the serviced channel.
- in_service  out  1  handler active.
- pending  out  N_CH  current pending register.

Behaviour:
- Reset (synchronous):
  - state = IDLE; pending, req_q, sel_ch cleared.
  - All outputs 0; instruction = NOP_INSTR.
  - Reset mid-sequence aborts the sequence with no further outputs.
- Edge detect:
  - req_q <= int_req every cycle; edge = int_req & ~req_q.
  - pending[i] is set on edge[i].
  - pending[i] is cleared only in VEC for sel_ch; if a new edge arrives in that same cycle, the set wins.
  - Masked pending bits are retained and serviced once unmasked.
- Arbitration:
  - cand = pending & int_mask; sel_ch = lowest set index, registered on leaving IDLE.
- States:
  - IDLE: outputs 0. If cand != 0 and !hold and !reset -> PUSH_HI. A rising edge sampled at edge k gives pending at k and state PUSH_HI after edge k+1, unless held.
  - PUSH_HI: pc_stop = 1, instruction = PUSH_HI_INSTR -> PUSH_LO.
  - PUSH_LO: pc_stop = 1, instruction = PUSH_LO_INSTR -> DRAIN with cnt = DRAIN_CYCLES-1.
  - DRAIN: pc_stop = 1, instruction = NOP_INSTR. If cnt == 0 -> VEC, else cnt--.
  - VEC: pc_stop = 1, pc_change = 1, pc_value = VEC_BASE + sel_ch*VEC_STRIDE (zero-extended to PC_W, modulo 2^PC_W), ack[sel_ch] = 1, pending[sel_ch] cleared -> ACTIVE.
  - ACTIVE: in_service = 1, all other outputs 0. New edges keep latching into pending; no nesting. On rti_done -> IDLE. In IDLE, pending work is taken on the next cycle.
- Timing and signal rules:
  - Total injected sequence length = 2 + DRAIN_CYCLES + 1 cycles.
  - hold is sampled only in IDLE; once a sequence starts it runs to completion regardless of hold.
  - rti_done outside ACTIVE is ignored.
  - Mask changes after the IDLE decision do not affect sel_ch.
  - Level-high int_req without a new edge does not re-request.
  - Simultaneous edges on several channels: the lowest index is serviced first; the others stay pending and are serviced sequentially after each rti_done.

Test Plan:
- Reset, then int_req[2] 0->1 with mask = 4'hF, VEC_BASE = 0, VEC_STRIDE = 2, DRAIN_CYCLES = 3:
  - pc_stop high for 6 cycles starting 2 cycles after sampling.
  - instruction sequence PUSH_HI, PUSH_LO, NOP, NOP, NOP.
  - pc_value = 4 with pc_change and ack = 4'b0100 in the 6th cycle; in_service follows.
- int_req = 4'b1010 on the same edge:
  - Channel 1 is serviced (pc_value = 2); pending = 4'b1000 persists.
  - rti_done pulse, then channel 3 is serviced (pc_value = 6).
- int_mask = 4'b1110 with an edge on channel 0: no sequence, pending[0] = 1. Set mask[0] = 1 -> service starts 1 cycle later.
- hold = 1 for 5 cycles with pending[1] set: stays IDLE. Release hold -> PUSH_HI on the next cycle. Asserting hold mid-DRAIN does not stall the sequence.
- Reset asserted during DRAIN:
  - Next cycle all outputs 0 and pending = 0.
  - A subsequent edge is serviced normally.
- int_req held high through ACTIVE and rti_done: no second service. Channel-0 edge arriving in the VEC cycle of channel 0 leaves pending[0] = 1 and is serviced after rti_done.
